// File: rtl/tt_sweep_characterizer.sv
// Truth-table characterizer for a 3-input gate: steps the eight input rows, samples the
// gate output and rebuilds its 8-bit code. Define TT_VOTE_EN for 2-of-3 majority sampling.
module tt_sweep_characterizer #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expect_code,
  input  logic       dut_out,
  output logic [2:0] stim,
  output logic       busy,
  output logic       done,
  output logic [7:0] code,
  output logic       pass
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    FINISH
  } state_t;

  // With a one-cycle settle time there is nothing to wait for, so a row goes straight to SAMPLE.
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam state_t     FIRST_WAIT  = (SETTLE_CYCLES == 1) ? SAMPLE : SETTLE;

  state_t     state_q, state_d;
  logic [2:0] row_q, row_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] code_q, code_d;
  logic       pass_q, pass_d;
  logic       done_q, done_d;
  logic       commit;
  logic       sample_bit;

`ifdef TT_VOTE_EN
  logic [1:0] vote_idx_q, vote_idx_d;
  logic [1:0] votes_q, votes_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= 3'd0;
      cnt_q    <= 8'd0;
      shadow_q <= 8'd0;
      code_q   <= 8'd0;
      pass_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef TT_VOTE_EN
      vote_idx_q <= 2'd0;
      votes_q    <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      code_q   <= code_d;
      pass_q   <= pass_d;
      done_q   <= done_d;
`ifdef TT_VOTE_EN
      vote_idx_q <= vote_idx_d;
      votes_q    <= votes_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    code_d     = code_q;
    pass_d     = pass_q;
    done_d     = 1'b0;
    commit     = 1'b0;
    sample_bit = 1'b0;
`ifdef TT_VOTE_EN
    vote_idx_d = vote_idx_q;
    votes_d    = votes_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          row_d    = 3'd0;
          shadow_d = 8'd0;
          cnt_d    = SETTLE_LOAD;
          state_d  = FIRST_WAIT;
        end
      end
      SETTLE: begin
        if (cnt_q <= 8'd1) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SAMPLE: begin
`ifdef TT_VOTE_EN
        // Two samples are parked, the third arrives live and the majority is stored.
        if (vote_idx_q == 2'd2) begin
          commit     = 1'b1;
          sample_bit = (votes_q[0] & votes_q[1]) | (votes_q[0] & dut_out) | (votes_q[1] & dut_out);
          vote_idx_d = 2'd0;
        end else begin
          votes_d[vote_idx_q[0]] = dut_out;
          vote_idx_d             = vote_idx_q + 2'd1;
        end
`else
        commit     = 1'b1;
        sample_bit = dut_out;
`endif
      end
      FINISH: begin
        code_d  = shadow_q;
        pass_d  = (shadow_q == expect_code);
        done_d  = 1'b1;
        row_d   = 3'd0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Row r lands in code bit 7-r, so row 000 is the MSB as in the gate library numbering.
    if (commit) begin
      shadow_d[3'd7 - row_q] = sample_bit;
      if (row_q == 3'd7) begin
        state_d = FINISH;
      end else begin
        row_d   = row_q + 3'd1;
        cnt_d   = SETTLE_LOAD;
        state_d = FIRST_WAIT;
      end
    end

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      row_d   = 3'd0;
      code_d  = code_q;
      pass_d  = pass_q;
      done_d  = 1'b0;
`ifdef TT_VOTE_EN
      vote_idx_d = 2'd0;
`endif
    end
  end

  assign stim = row_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign code = code_q;
  assign pass = pass_q;

endmodule

// File: tb/tb_tt_sweep_characterizer.sv
// Self-checking bench for tt_sweep_characterizer: a cycle-count model of the sweep plus a
// gate model whose output is wrong until settled (and, with TT_VOTE_EN, glitches once per row).
module tb_tt_sweep_characterizer;

`ifdef TT_VOTE_EN
  localparam int S = 2;
  localparam int P = S + 2;
`else
  localparam int S = 4;
  localparam int P = S;
`endif
  localparam int SWEEP_EDGES = 8 * P + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] expect_code = 8'h00;
  logic       dut_out = 1'b0;
  logic [2:0] stim;
  logic       busy;
  logic       done;
  logic [7:0] code;
  logic       pass;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] gate_code = 8'h00;

  tt_sweep_characterizer #(.SETTLE_CYCLES(S)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .expect_code(expect_code),
    .dut_out(dut_out),
    .stim(stim),
    .busy(busy),
    .done(done),
    .code(code),
    .pass(pass)
  );

  always #5 clk = ~clk;

  // Sweep model: m_k counts edges since the accepting edge; the sweep occupies edges 0..8P.
  logic       m_active = 1'b0;
  int         m_k = 0;
  logic       m_done = 1'b0;
  logic [7:0] m_code = 8'h00;
  logic       m_pass = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_done   <= 1'b0;
      m_code   <= 8'h00;
      m_pass   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (!m_active) begin
        if (start && !abort) begin
          m_active <= 1'b1;
          m_k      <= 0;
        end
      end else if (abort) begin
        m_active <= 1'b0;
      end else if (m_k == 8 * P) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
        m_code   <= gate_code;
        m_pass   <= (gate_code == expect_code);
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  function automatic logic [2:0] exp_stim();
    if (!m_active) return 3'd0;
    if (m_k / P >= 7) return 3'd7;
    return 3'(m_k / P);
  endfunction

  // Gate under test: only the cycles feeding real sample edges carry the correct value.
  always @(negedge clk) begin : gate_model
    int   p;
    int   r;
    logic good;
    good = gate_code[3'd7 - stim];
    if (m_active && m_k < 8 * P) begin
      p = m_k % P;
      r = m_k / P;
`ifdef TT_VOTE_EN
      dut_out = (p < S - 1 || p == S - 1 + (r % 3)) ? ~good : good;
`else
      dut_out = (p != S - 1) ? ~good : good;
`endif
    end else begin
      dut_out = good;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a);
    @(negedge clk);
    start = s;
    abort = a;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("stim", 32'(stim), 32'(exp_stim()));
      checkOutput("busy", 32'(busy), 32'(m_active));
      checkOutput("done", 32'(done), 32'(m_done));
      checkOutput("code", 32'(code), 32'(m_code));
      checkOutput("pass", 32'(pass), 32'(m_pass));
    end
  end

  // Runs one sweep; returns the edge index (0 = accepting edge) at which done was seen.
  task automatic runSweep(input logic [7:0] gate, input logic [7:0] expc, input bit pokes,
                          output int done_edge);
    gate_code   = gate;
    expect_code = expc;
    applyStimulus(1'b1, 1'b0);
    done_edge = -1;
    for (int i = 0; i < SWEEP_EDGES + 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      start = pokes && (i == 5 || i == 17);
      if (done) begin
        done_edge = i;
        break;
      end
    end
    if (done_edge < 0) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitEdges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    int e;
    int n_done;
    int first_done;
    int second_done;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_stim", 32'(stim), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_code", 32'(code), 32'h00);
    checkOutput("reset_pass", 32'(pass), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] sweep of a 0x02 gate");
    runSweep(8'h02, 8'h02, 1'b0, e);
    checkOutput("sweep02_done_edge", 32'(e), 32'd33);
    checkOutput("sweep02_code", 32'(code), 32'h02);
    checkOutput("sweep02_pass", 32'(pass), 32'd1);
    waitEdges(3);

    $display("[TB] abort during row 5");
    gate_code = 8'h55;
    applyStimulus(1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    waitEdges(5 * P);
    checkOutput("abort_row", 32'(stim), 32'd5);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_stim", 32'(stim), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_code", 32'(code), 32'h02);
    waitEdges(2 * P);

    $display("[TB] majority gate with start pokes while busy");
    runSweep(8'h17, 8'h02, 1'b1, e);
    checkOutput("maj_done_edge", 32'(e), 32'd33);
    checkOutput("maj_code", 32'(code), 32'h17);
    checkOutput("maj_pass", 32'(pass), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("maj_done_single", 32'(done), 32'd0);

    $display("[TB] asynchronous reset during row 3");
    gate_code = 8'h33;
    applyStimulus(1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    waitEdges(3 * P);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_stim", 32'(stim), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_code", 32'(code), 32'h00);
    checkOutput("arst_pass", 32'(pass), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    runSweep(8'h17, 8'h17, 1'b0, e);
    checkOutput("post_rst_done_edge", 32'(e), 32'd33);
    checkOutput("post_rst_code", 32'(code), 32'h17);
    checkOutput("post_rst_pass", 32'(pass), 32'd1);
    waitEdges(2);

    $display("[TB] all-ones gate");
    runSweep(8'hFF, 8'hFF, 1'b0, e);
    checkOutput("ff_done_edge", 32'(e), 32'd33);
    checkOutput("ff_code", 32'(code), 32'hFF);
    waitEdges(2);

    $display("[TB] start held for back-to-back sweeps");
    gate_code   = 8'hA5;
    expect_code = 8'hA5;
    applyStimulus(1'b1, 1'b0);
    n_done      = 0;
    first_done  = -1;
    second_done = -1;
    for (int i = 0; i < 2 * SWEEP_EDGES + 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        n_done++;
        if (n_done == 1) first_done = i;
        if (n_done == 2) second_done = i;
      end
    end
    checkOutput("held_done_count", 32'(n_done), 32'd2);
    checkOutput("held_first_done", 32'(first_done), 32'd33);
    checkOutput("held_second_done", 32'(second_done), 32'd67);
    checkOutput("held_code", 32'(code), 32'hA5);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("held_abort_busy", 32'(busy), 32'd0);

    $display("[TB] abort and start together in idle");
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("abort_start_busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("idle_abort_code", 32'(code), 32'hA5);
    waitEdges(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_sweep_characterizer.md
# tt_sweep_characterizer

- Sequential characterizer: the reading end of a 3-input logic gate.
- Drives all eight input rows into a combinational gate under test, waits for the output to settle, and samples it.
- Reconstructs the gate's 8-bit truth-table code in the same hex numbering the gate library uses (e.g. 0x02).
- Sits in the verification/bring-up harness next to the gate library, one instance per gate under test.

## Interface
Parameters:
- SETTLE_CYCLES, 4: clock cycles each row is held before the first sample; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  begin a sweep; honoured only in IDLE.
- abort  input  1  cancel a sweep in progress.
- expect_code  input  8  code the gate is supposed to implement; compared at completion.
- dut_out  input  1  output of the gate under test.
- stim  output  3  drives the gate's {in1,in2,in3}; in1 is the MSB.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- code  output  8  last measured truth-table code.
- pass  output  1  code == expect_code, latched at completion.

## Operation
- Code mapping: for row index r = {in1,in2,in3}, code[7-r] = sampled dut_out. Row 3'b000 maps to code[7] and row 3'b111 to code[0]; row 3'b110 alone high gives 0x02.
- FSM states: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE:
  - stim=000, busy=0.
  - start=1 → SETTLE; row counter=0, stim=000, settle counter loaded.
- SETTLE: count SETTLE_CYCLES edges from the row-drive edge, then → SAMPLE.
- SAMPLE:
  - Capture dut_out into shadow register bit 7-r.
  - If r<7: r+1, stim=r+1, → SETTLE.
  - If r=7: → FINISH.
- FINISH (one cycle):
  - code ← shadow, pass ← (shadow == expect_code).
  - done=1, then → IDLE.
- code and pass change only in FINISH. Partial results are never visible.
- start while busy is ignored. start in the same cycle as FINISH is ignored; start is accepted from the next IDLE cycle.
- abort while busy:
  - → IDLE on the next edge, stim=000.
  - No done pulse; code and pass are unchanged.
- abort and start together in IDLE: abort wins and no sweep starts.
- abort in IDLE otherwise: no effect.
- Reset mid-sweep: immediate return to IDLE, all outputs to reset values. The sweep is not resumed.

## Timing
- Reset values: stim=000, busy=0, done=0, code=8'h00, pass=0.
- Edge 0 is the edge at which start is accepted: busy=1, stim=000.
- Row r is driven at edge E_r = r·S, where S = SETTLE_CYCLES.
- Without TT_VOTE_EN:
  - dut_out for row r is sampled at edge E_r+S; the next row is driven at that same edge.
  - Row 7 is sampled at edge 8·S.
  - code, pass and done are valid after edge 8·S+1; busy falls at that same edge.
  - Total busy length is 8·S+1 cycles.
- stim is registered and changes only on row-drive edges. No glitches between rows.

## Configuration
- Macro: TT_VOTE_EN.
- Defined:
  - Each row is sampled on three consecutive edges E_r+S, E_r+S+1, E_r+S+2; the stored bit is the 2-of-3 majority.
  - Row period is S+2, so E_r = r·(S+2). The completion edge is 8·(S+2)+1.
  - stim holds through all three samples.
- Undefined: single sample per row, timing as in Timing. No vote logic is present.

## Test plan
- Behavioural 0x02 gate on dut_out, S=4, expect_code=0x02, pulse start → stim steps 000..111 every 4 cycles; done at cycle 33; code=0x02, pass=1, busy low afterwards.
- Majority-gate model (code 0x17), expect_code=0x02 → code=0x17, pass=0, single-cycle done.
- Assert abort during row 5 → busy drops next edge, stim=000, no done; code still holds the previous 0x02.
- Assert rst asynchronously mid-row-3 → all outputs zero immediately; a subsequent start gives a correct full sweep.
- start held high continuously for two sweeps → second sweep begins at the cycle after FINISH; start pulses during busy are ignored.
- TT_VOTE_EN defined, S=2, dut_out glitching for exactly one sample cycle per row on an 0xFF gate → code=0xFF; done at cycle 8·4+1=33.
